hv_efuse_load_ctrl: RTL and testbench
=====================================

# hv_efuse_load_ctrl

Downstream consumer of the HV control FSM's efuse load request: on `o_efuse_load_req` from `hv_ctrl_unit` it sequences word-by-word reads of the efuse macro. It writes each word into the register bank, then checks the image and reports completion. Its `o_efuse_load_done` and `o_efuse_vld` feed back into the control FSM as `i_efuse_load_done` and `i_reg_efuse_vld`.

## Interface
Parameters:
- `EFUSE_WORD_NUM`, default 8: number of efuse words loaded; the last word is the checksum word. Legal range is 2 to 16.
- `EFUSE_DW`, default 8: efuse word width.
- `EFUSE_AW`, default 4: address width; must satisfy `2**EFUSE_AW >= EFUSE_WORD_NUM`.
- `RD_PLS_CYC`, default 4: number of cycles the read strobe is held high. Must be ≥1.
- `RD_WAIT_CYC`, default 2: number of cycles after the strobe falls before data is sampled. Must be ≥1.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset. Asynchronous, active-low.
- `i_efuse_load_req`, in, 1: level request from the control FSM.
- `i_efuse_ctrl_reg_en`, in, 1: load permission; this is the efuse control register enable.
- `o_efuse_addr`, out, `EFUSE_AW`: efuse macro word address.
- `o_efuse_rd_stb`, out, 1: efuse macro read strobe.
- `i_efuse_rdata`, in, `EFUSE_DW`: efuse macro read data.
- `o_reg_wr_en`, out, 1: register bank write, one-cycle pulse.
- `o_reg_wr_addr`, out, `EFUSE_AW`: register bank word index.
- `o_reg_wr_data`, out, `EFUSE_DW`: register bank write data.
- `o_efuse_busy`, out, 1: high in every state except IDLE.
- `o_efuse_load_done`, out, 1: one-cycle completion pulse.
- `o_efuse_vld`, out, 1: sticky image-valid flag.

## Operation
- **Reset values:** every output is 0. The FSM starts in IDLE. The word index, data register and checksum accumulator are all 0. The arm flag is 1.
- **Arm flag:**
  - Clears when a load starts.
  - Sets on any cycle in IDLE where `i_efuse_load_req` = 0.
  - A request held high across a completed load therefore never retriggers.
- **FSM states:** IDLE, STB, WAIT, WR, CHK, DONE. All outputs are decoded from registered state and counters.
- **IDLE**
  - Exits to STB when `i_efuse_load_req & i_efuse_ctrl_reg_en & arm`.
  - On that edge: word index ← 0, accumulator ← 0, `o_efuse_vld` ← 0.
- **STB**
  - `o_efuse_rd_stb` = 1 and `o_efuse_addr` = word index.
  - After `RD_PLS_CYC` cycles, go to WAIT.
- **WAIT**
  - Strobe is 0 and the address is held.
  - On the last of `RD_WAIT_CYC` cycles, `i_efuse_rdata` is captured into the data register. Go to WR.
- **WR**
  - `o_reg_wr_en` = 1, `o_reg_wr_addr` = word index, `o_reg_wr_data` = data register.
  - For index < `EFUSE_WORD_NUM-1`: accumulator ^= data. The OR-reduce nonzero flag also updates for every word.
  - If index = `EFUSE_WORD_NUM-1`, go to CHK. Otherwise increment the index and go to STB.
- **CHK:** one cycle. Sets `o_efuse_vld` per the Configuration section, then go to DONE.
- **DONE:** `o_efuse_load_done` = 1 for exactly one cycle, then go to IDLE.
- **Abort:**
  - If `i_efuse_ctrl_reg_en` = 0 in any of STB, WAIT or WR, the FSM returns to IDLE on the next edge.
  - No write occurs in that cycle, and no done pulse is issued.
  - `o_efuse_vld` stays 0. The arm flag stays clear until the request drops.
- **Simultaneous events:**
  - Abort takes priority over the WR→CHK transition.
  - A request arriving during a load is ignored.
- **Reset during a load:** immediate return to reset values. The partially written register bank is not cleaned; it stays as written.

## Timing
- Start edge E0 is the IDLE→STB transition.
- Word k occupies `RD_PLS_CYC + RD_WAIT_CYC + 1` cycles, starting at E0 + k·(that sum).
- CHK is entered at E0 + `EFUSE_WORD_NUM`·(`RD_PLS_CYC+RD_WAIT_CYC+1`). With defaults this is E0+56.
- DONE, and therefore the done pulse, follows at E0+57 with defaults.
- `o_efuse_vld` is valid from the cycle the done pulse is high.
- Addr/data setup: the address is stable from the first STB cycle through the sample cycle.
- Back-to-back loads: the next start is no earlier than 1 cycle after the request has been seen low in IDLE.

## Configuration
- **`HV_EFUSE_CRC_CHK_EN` defined:**
  - `o_efuse_vld` = (accumulator == checksum word) & nonzero flag.
  - The nonzero flag covers words 0..N-2.
- **Undefined:**
  - `o_efuse_vld` = nonzero flag over all words (blank-fuse detection only).
  - The checksum word is still read and written to the register bank.

## Test plan
- **Nominal load, macro defined:** words 0..6 = 0x01..0x07 and word 7 = 0x00 (XOR of 0x01..0x07). Required: 8 writes at addr 0..7 with matching data; done at E0+57; `o_efuse_vld` = 1.
- **Checksum mismatch, macro defined:** word 7 = 0x5A. Required: done at E0+57 and `o_efuse_vld` = 0. The same image with the macro undefined gives `o_efuse_vld` = 1.
- **Blank fuse:** all words 0x00. Required: `o_efuse_vld` = 0 both with and without the macro.
- **Abort:** drop `i_efuse_ctrl_reg_en` during the WAIT of word 3. Required: exactly 3 writes; IDLE on the next edge; no done pulse; `o_efuse_vld` = 0. A new load requires the request low, then high.
- **Held request:** keep `i_efuse_load_req` = 1 for 100 cycles after done. Required: no second load. Dropping the request for 1 cycle and raising it again starts a new load, and `o_efuse_vld` clears at the new E0.
- **Async reset at E0+20:** required: all outputs 0 immediately; the next request starts a load from word 0.

Source files
------------

// File: rtl/hv_efuse_load_ctrl.sv
// -----------------------------------------------------------------------------
// hv_efuse_load_ctrl
//
// Purpose:
//   On a level load request from the HV control FSM, reads the efuse macro
//   word by word (strobe, wait, sample), copies each word into the register
//   bank, then checks the loaded image. It signals completion with a one-cycle
//   done pulse and a sticky image-valid flag.
//
// Optional feature (compile-time macro):
//   HV_EFUSE_CRC_CHK_EN - when defined, the image is valid only if the XOR of
//   words 0..N-2 equals the last (checksum) word and those words are not all
//   zero. When undefined, the image is valid when any word is nonzero
//   (blank-fuse detection only). The checksum word is always read and written.
//
// Ports:
//   i_clk               clock
//   i_rst_n             asynchronous active-low reset
//   i_efuse_load_req    level load request
//   i_efuse_ctrl_reg_en load permission; dropping it mid-load aborts the load
//   o_efuse_addr        efuse macro word address (driven in STB/WAIT)
//   o_efuse_rd_stb      efuse macro read strobe
//   i_efuse_rdata       efuse macro read data
//   o_reg_wr_en         register bank write pulse
//   o_reg_wr_addr       register bank word index
//   o_reg_wr_data       register bank write data
//   o_efuse_busy        high whenever the FSM is not idle
//   o_efuse_load_done   one-cycle completion pulse
//   o_efuse_vld         sticky image-valid flag
// -----------------------------------------------------------------------------
module hv_efuse_load_ctrl #(
  parameter int EFUSE_WORD_NUM = 8,
  parameter int EFUSE_DW       = 8,
  parameter int EFUSE_AW       = 4,
  parameter int RD_PLS_CYC     = 4,
  parameter int RD_WAIT_CYC    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_efuse_load_req,
  input  logic                i_efuse_ctrl_reg_en,
  output logic [EFUSE_AW-1:0] o_efuse_addr,
  output logic                o_efuse_rd_stb,
  input  logic [EFUSE_DW-1:0] i_efuse_rdata,
  output logic                o_reg_wr_en,
  output logic [EFUSE_AW-1:0] o_reg_wr_addr,
  output logic [EFUSE_DW-1:0] o_reg_wr_data,
  output logic                o_efuse_busy,
  output logic                o_efuse_load_done,
  output logic                o_efuse_vld
);

  // Phase counter only has to reach the longer of the two phases.
  localparam int CNT_MAX = (RD_PLS_CYC > RD_WAIT_CYC) ? RD_PLS_CYC : RD_WAIT_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]       PLS_LAST  = CW'(RD_PLS_CYC - 1);
  localparam logic [CW-1:0]       WAIT_LAST = CW'(RD_WAIT_CYC - 1);
  localparam logic [EFUSE_AW-1:0] IDX_LAST  = EFUSE_AW'(EFUSE_WORD_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STB  = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [EFUSE_AW-1:0] idx_q, idx_d;
  logic [EFUSE_DW-1:0] data_q, data_d;
  logic [EFUSE_DW-1:0] acc_q, acc_d;
  logic                nz_q, nz_d;
  logic                vld_q, vld_d;
  logic                arm_q, arm_d;
  logic                start_s;
  logic                last_word_s;

  assign start_s     = (state_q == S_IDLE) & i_efuse_load_req & i_efuse_ctrl_reg_en & arm_q;
  assign last_word_s = (idx_q == IDX_LAST);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped enable in STB/WAIT/WR wins over any other move.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = S_STB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STB: begin
        if (!i_efuse_ctrl_reg_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == PLS_LAST) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_STB;
        end
      end
      S_WAIT: begin
        if (!i_efuse_ctrl_reg_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_WR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WR: begin
        if (!i_efuse_ctrl_reg_en) begin
          state_d = S_IDLE;
        end else if (last_word_s) begin
          state_d = S_CHK;
        end else begin
          state_d = S_STB;
        end
      end
      S_CHK:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: phase counter, word index, sampled data, checks, arm.
  always_comb begin
    cnt_d  = '0;
    idx_d  = idx_q;
    data_d = data_q;
    acc_d  = acc_q;
    nz_d   = nz_q;
    vld_d  = vld_q;
    arm_d  = arm_q;

    // The counter runs only while staying inside STB or WAIT; any state change
    // (including abort) restarts it for the next phase.
    if (((state_q == S_STB) || (state_q == S_WAIT)) && (state_d == state_q)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        // Re-arming needs the request seen low, so a held request cannot retrigger.
        if (!i_efuse_load_req) begin
          arm_d = 1'b1;
        end else if (start_s) begin
          arm_d = 1'b0;
          idx_d = '0;
          acc_d = '0;
          nz_d  = 1'b0;
          vld_d = 1'b0;
        end else begin
          arm_d = arm_q;
        end
      end
      S_WAIT: begin
        if (i_efuse_ctrl_reg_en && (cnt_q == WAIT_LAST)) begin
          data_d = i_efuse_rdata;
        end else begin
          data_d = data_q;
        end
      end
      S_WR: begin
        if (i_efuse_ctrl_reg_en) begin
          if (!last_word_s) begin
            acc_d = acc_q ^ data_q;
            idx_d = idx_q + EFUSE_AW'(1);
          end else begin
            acc_d = acc_q;
            idx_d = idx_q;
          end
`ifdef HV_EFUSE_CRC_CHK_EN
          // The checksum word itself does not count towards "not blank".
          if (!last_word_s) begin
            nz_d = nz_q | (|data_q);
          end else begin
            nz_d = nz_q;
          end
`else
          nz_d = nz_q | (|data_q);
`endif
        end else begin
          idx_d = idx_q;
        end
      end
      S_CHK: begin
`ifdef HV_EFUSE_CRC_CHK_EN
        // data_q still holds the checksum word captured for the last WR.
        vld_d = (acc_q == data_q) & nz_q;
`else
        vld_d = nz_q;
`endif
      end
      default: begin
        vld_d = vld_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      acc_q  <= '0;
      nz_q   <= 1'b0;
      vld_q  <= 1'b0;
      arm_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      acc_q  <= acc_d;
      nz_q   <= nz_d;
      vld_q  <= vld_d;
      arm_q  <= arm_d;
    end
  end

  // Outputs decoded from registered state. The write is suppressed in the
  // abort cycle so an aborted WR never reaches the register bank.
  assign o_efuse_busy      = (state_q != S_IDLE);
  assign o_efuse_rd_stb    = (state_q == S_STB);
  assign o_efuse_addr      = ((state_q == S_STB) || (state_q == S_WAIT)) ? idx_q : '0;
  assign o_reg_wr_en       = (state_q == S_WR) & i_efuse_ctrl_reg_en;
  assign o_reg_wr_addr     = (state_q == S_WR) ? idx_q : '0;
  assign o_reg_wr_data     = (state_q == S_WR) ? data_q : '0;
  assign o_efuse_load_done = (state_q == S_DONE);
  assign o_efuse_vld       = vld_q;

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hv_efuse_load_ctrl
//
// Self-checking bench for hv_efuse_load_ctrl with default parameters. An efuse
// macro model returns valid data only on the last wait cycle after the strobe
// falls; a negedge monitor logs writes, start edges and done pulses; expected
// values come from image-level rules (XOR / nonzero over the word array).
// -----------------------------------------------------------------------------
module tb_hv_efuse_load_ctrl;

  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int PLS  = 4;
  localparam int WT   = 2;
  localparam int WORD = PLS + WT + 1;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          en;
  logic [AW-1:0] efuse_addr;
  logic          rd_stb;
  logic [DW-1:0] rdata;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          vld;

  hv_efuse_load_ctrl #(
    .EFUSE_WORD_NUM(N), .EFUSE_DW(DW), .EFUSE_AW(AW),
    .RD_PLS_CYC(PLS), .RD_WAIT_CYC(WT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_efuse_load_req(req),
    .i_efuse_ctrl_reg_en(en), .o_efuse_addr(efuse_addr), .o_efuse_rd_stb(rd_stb),
    .i_efuse_rdata(rdata), .o_reg_wr_en(wr_en), .o_reg_wr_addr(wr_addr),
    .o_reg_wr_data(wr_data), .o_efuse_busy(busy), .o_efuse_load_done(done),
    .o_efuse_vld(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int low_cnt  = 0;
  logic [DW-1:0] mem [16];
  logic busy_prev = 1'b0;

  int            e0_q[$];
  int            wc_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            dc_q[$];
  logic          dv_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: data is only correct on the last wait cycle after the strobe.
  always @(posedge clk) low_cnt <= rd_stb ? 0 : ((low_cnt < 1000) ? low_cnt + 1 : low_cnt);
  assign rdata = (!rd_stb && low_cnt == WT - 1) ? mem[efuse_addr] : ~mem[efuse_addr];

  // Monitor: log starts, writes and done pulses; the strobed address must be
  // the index of the next word to be written.
  always @(negedge clk) begin
    if (busy && !busy_prev) e0_q.push_back(cyc);
    busy_prev = busy;
    if (rd_stb) chk("stb_addr", 32'(efuse_addr), 32'(wa_q.size()));
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
    if (done) begin
      dc_q.push_back(cyc);
      dv_q.push_back(vld);
    end
  end

  function automatic logic exp_vld();
    logic [DW-1:0] acc;
    logic          nz;
    acc = '0;
    nz  = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      acc = acc ^ mem[k];
      nz  = nz | (mem[k] != '0);
    end
`ifdef HV_EFUSE_CRC_CHK_EN
    return (acc == mem[N-1]) && nz;
`else
    return nz || (mem[N-1] != '0);
`endif
  endfunction

  task automatic clear_logs();
    e0_q.delete(); wc_q.delete(); wa_q.delete(); wd_q.delete(); dc_q.delete(); dv_q.delete();
  endtask

  task automatic wait_start(input string tag);
    int t;
    t = 0;
    while (e0_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_start_seen"}, 32'(e0_q.size() > 0), 32'd1);
  endtask

  task automatic run_load(input string tag, input bit keep_req);
    int  t, e0;
    logic ev;
    ev = exp_vld();
    clear_logs();
    en  = 1'b1;
    req = 1'b1;
    wait_start(tag);
    e0 = (e0_q.size() > 0) ? e0_q[0] : 0;
    chk({tag, "_vld_clr_at_e0"}, 32'(vld), 32'd0);
    t = 0;
    while (dc_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_done_seen"}, 32'(dc_q.size()), 32'd1);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(N));
    for (int k = 0; k < N && k < wa_q.size(); k++) begin
      chk({tag, "_wr_addr"}, 32'(wa_q[k]), 32'(k));
      chk({tag, "_wr_data"}, 32'(wd_q[k]), 32'(mem[k]));
      chk({tag, "_wr_cyc"}, 32'(wc_q[k] - e0), 32'(k * WORD + PLS + WT));
    end
    if (dc_q.size() > 0) begin
      chk({tag, "_done_cyc"}, 32'(dc_q[0] - e0), 32'(N * WORD + 1));
      chk({tag, "_vld_at_done"}, 32'(dv_q[0]), 32'(ev));
    end
    if (!keep_req) req = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_vld_sticky"}, 32'(vld), 32'(ev));
    chk({tag, "_single_done"}, 32'(dc_q.size()), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stb"}, 32'(rd_stb), 32'd0);
    chk({tag, "_addr"}, 32'(efuse_addr), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
  endtask

  initial begin
    int e0, bcnt;
    logic [DW-1:0] x;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    rst_n = 1'b0;
    req   = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Nominal image: 01..07 with XOR checksum 00.
    for (int k = 0; k < N - 1; k++) mem[k] = DW'(k + 1);
    mem[N-1] = 8'h00;
    run_load("nominal", 1'b0);

    // Checksum mismatch.
    mem[N-1] = 8'h5A;
    run_load("mismatch", 1'b0);

    // Blank fuse; the previous load left vld high, so the clear at E0 is visible.
    mem[N-1] = 8'h00;
    run_load("nominal2", 1'b0);
    for (int k = 0; k < N; k++) mem[k] = 8'h00;
    run_load("blank", 1'b0);

    // Randomized images, half with a correct checksum.
    for (int it = 0; it < 6; it++) begin
      x = '0;
      for (int k = 0; k < N - 1; k++) begin
        mem[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
        x = x ^ mem[k];
      end
      mem[N-1] = (it % 2 == 0) ? x : DW'($urandom);
      run_load("random", 1'b0);
    end

    // Abort during WAIT of word 3, after a valid load.
    for (int k = 0; k < N - 1; k++) mem[k] = DW'(k + 1);
    mem[N-1] = 8'h00;
    run_load("pre_abort", 1'b0);
    clear_logs();
    req = 1'b1;
    wait_start("abort");
    e0 = (e0_q.size() > 0) ? e0_q[0] : cyc;
    bcnt = 0;
    while (cyc < e0 + 3 * WORD + PLS && bcnt < 100) begin @(negedge clk); bcnt++; end
    en = 1'b0;
    @(negedge clk);
    chk("abort_idle_next_edge", 32'(busy), 32'd0);
    chk("abort_nwrites", 32'(wa_q.size()), 32'd3);
    chk("abort_vld", 32'(vld), 32'd0);
    en = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_restart", 32'(e0_q.size()), 32'd1);
    chk("abort_no_done", 32'(dc_q.size()), 32'd0);
    req = 1'b0;
    @(negedge clk);
    run_load("after_abort", 1'b0);

    // Held request: no retrigger for 100 cycles; one low cycle re-arms.
    run_load("held", 1'b1);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("held_no_reload", 32'(bcnt), 32'd0);
    req = 1'b0;
    @(negedge clk);
    run_load("rearm", 1'b0);

    // Asynchronous reset at E0+20, mid-load.
    for (int k = 0; k < N - 1; k++) mem[k] = DW'($urandom_range(1, 255));
    x = '0;
    for (int k = 0; k < N - 1; k++) x = x ^ mem[k];
    mem[N-1] = x;
    clear_logs();
    req = 1'b1;
    wait_start("rst");
    e0 = (e0_q.size() > 0) ? e0_q[0] : cyc;
    bcnt = 0;
    while (cyc < e0 + 20 && bcnt < 100) begin @(negedge clk); bcnt++; end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    run_load("post_rst", 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
